// File: rtl/align_seq.sv
// align_seq: acquisition sequencer for the SDI word aligner and TRS detector.
// It resets the detector, pulses the aligner, then searches for consistent TRS.
// On a timed-out search it retries the align, and after MAX_RETRIES failed
// windows it parks in FAIL. While locked, a run of TRS errors forces re-acquisition.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | disabled, all counters clear
// DRST   | detector held in reset for SETTLE_CYCLES
// ALIGN  | align pulse to the aligner for ALIGN_PULSE cycles
// SEARCH | counting consecutive good TRS inside a CHECK_CYCLES window
// LOCKED | alignment declared, watching for consecutive TRS errors
// FAIL   | retries exhausted, held until enable_i drops
module align_seq #(
    parameter int SETTLE_CYCLES = 64,
    parameter int ALIGN_PULSE   = 5,
    parameter int CHECK_CYCLES  = 1024,
    parameter int LOCK_COUNT    = 4,
    parameter int ERR_LIMIT     = 3,
    parameter int MAX_RETRIES   = 15
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       enable_i,
    input  logic       trs_valid_i,
    input  logic       trs_err_i,
    output logic       align_o,
    output logic       det_rst_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [7:0] retries_o,
    output logic [2:0] state_o
);

    // One shared down-counter times DRST, ALIGN and the SEARCH window.
    localparam int TMR_MAX0 = (SETTLE_CYCLES > ALIGN_PULSE) ? SETTLE_CYCLES : ALIGN_PULSE;
    localparam int TMR_MAX  = (TMR_MAX0 > CHECK_CYCLES) ? TMR_MAX0 : CHECK_CYCLES;
    localparam int TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int GOOD_W   = $clog2(LOCK_COUNT + 1);
    localparam int ERR_W    = $clog2(ERR_LIMIT + 1);

    localparam logic [TMR_W-1:0]  SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  ALIGN_LD  = TMR_W'(ALIGN_PULSE - 1);
    localparam logic [TMR_W-1:0]  CHECK_LD  = TMR_W'(CHECK_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_TC   = GOOD_W'(LOCK_COUNT);
    localparam logic [ERR_W-1:0]  ERR_TC    = ERR_W'(ERR_LIMIT);
    localparam logic [7:0]        RETRY_TC  = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRST   = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_SEARCH = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    state_t            state_q,   state_d;
    logic [TMR_W-1:0]  tmr_q,     tmr_d;
    logic [GOOD_W-1:0] good_q,    good_d;
    logic [ERR_W-1:0]  err_q,     err_d;
    logic [7:0]        retries_q, retries_d;
    logic [GOOD_W-1:0] good_nx;
    logic [ERR_W-1:0]  err_nx;
    logic [7:0]        retry_nx;

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            good_q    <= '0;
            err_q     <= '0;
            retries_q <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            good_q    <= good_d;
            err_q     <= err_d;
            retries_q <= retries_d;
        end
    end

    // Next-state and counter update; enable_i low overrides every state.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        good_d    = good_q;
        err_d     = err_q;
        retries_d = retries_q;
        good_nx   = '0;
        err_nx    = '0;
        retry_nx  = '0;

        if (!enable_i) begin
            state_d   = ST_IDLE;
            tmr_d     = '0;
            good_d    = '0;
            err_d     = '0;
            retries_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_DRST;
                    tmr_d     = SETTLE_LD;
                    good_d    = '0;
                    err_d     = '0;
                    retries_d = '0;
                end
                ST_DRST: begin
                    if (tmr_q == '0) begin
                        state_d = ST_ALIGN;
                        tmr_d   = ALIGN_LD;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ST_ALIGN: begin
                    if (tmr_q == '0) begin
                        state_d = ST_SEARCH;
                        tmr_d   = CHECK_LD;
                        good_d  = '0;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ST_SEARCH: begin
                    // An error in the same cycle as a valid still breaks the run.
                    if (trs_err_i)
                        good_nx = '0;
                    else if (trs_valid_i)
                        good_nx = good_q + GOOD_W'(1);
                    else
                        good_nx = good_q;
                    good_d = good_nx;
                    // Lock wins over a window expiring on the same cycle.
                    if (good_nx == GOOD_TC) begin
                        state_d = ST_LOCKED;
                        err_d   = '0;
                    end else if (tmr_q == '0) begin
                        retry_nx  = (retries_q == 8'hFF) ? retries_q : retries_q + 8'd1;
                        retries_d = retry_nx;
                        if (retry_nx == RETRY_TC) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_ALIGN;
                            tmr_d   = ALIGN_LD;
                        end
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (trs_err_i)
                        err_nx = err_q + ERR_W'(1);
                    else if (trs_valid_i)
                        err_nx = '0;
                    else
                        err_nx = err_q;
                    err_d = err_nx;
                    if (err_nx == ERR_TC) begin
                        state_d   = ST_DRST;
                        tmr_d     = SETTLE_LD;
                        err_d     = '0;
                        retries_d = '0;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from the state register.
    assign align_o   = (state_q == ST_ALIGN);
    assign det_rst_o = (state_q == ST_DRST);
    assign locked_o  = (state_q == ST_LOCKED);
    assign fail_o    = (state_q == ST_FAIL);
    assign retries_o = retries_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_align_seq.sv
// tb_align_seq: directed stimulus for align_seq; expected output snapshots are
// queued with the cycle they must appear on, and a monitor checks them.
module tb_align_seq;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       enable_i;
    logic       trs_valid_i;
    logic       trs_err_i;
    logic       align_o;
    logic       det_rst_o;
    logic       locked_o;
    logic       fail_o;
    logic [7:0] retries_o;
    logic [2:0] state_o;

    align_seq #(
        .SETTLE_CYCLES(4),
        .ALIGN_PULSE  (5),
        .CHECK_CYCLES (32),
        .LOCK_COUNT   (4),
        .ERR_LIMIT    (3),
        .MAX_RETRIES  (3)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .enable_i   (enable_i),
        .trs_valid_i(trs_valid_i),
        .trs_err_i  (trs_err_i),
        .align_o    (align_o),
        .det_rst_o  (det_rst_o),
        .locked_o   (locked_o),
        .fail_o     (fail_o),
        .retries_o  (retries_o),
        .state_o    (state_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          cyc;
        logic [14:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Snapshot layout: {state[2:0], align, det_rst, locked, fail, retries[7:0]}
    function automatic logic [14:0] pk(logic [2:0] st, logic al, logic dr, logic lk,
                                       logic fl, logic [7:0] rt);
        return {st, al, dr, lk, fl, rt};
    endfunction
    function automatic logic [14:0] o_idle();              return pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0); endfunction
    function automatic logic [14:0] o_drst();              return pk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); endfunction
    function automatic logic [14:0] o_align(logic [7:0] r);  return pk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, r); endfunction
    function automatic logic [14:0] o_search(logic [7:0] r); return pk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, r); endfunction
    function automatic logic [14:0] o_locked();            return pk(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0); endfunction
    function automatic logic [14:0] o_fail(logic [7:0] r);   return pk(3'd5, 1'b0, 1'b0, 1'b0, 1'b1, r); endfunction

    task automatic expect_at(input int dly, input logic [14:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + dly;
        e.exp  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // One-cycle trs pulse; exp is the snapshot after the edge that samples it.
    task automatic pulse(input logic v, input logic e, input int gap,
                         input logic [14:0] exp, input string nm);
        trs_valid_i = v;
        trs_err_i   = e;
        expect_at(1, exp, nm);
        step();
        trs_valid_i = 1'b0;
        trs_err_i   = 1'b0;
        repeat (gap - 1) step();
    endtask

    // DRST x4, ALIGN x5 then SEARCH, starting on the next edge.
    task automatic push_acq(input string nm);
        for (int k = 1; k <= 4; k++) expect_at(k, o_drst(), {nm, "_drst"});
        for (int k = 5; k <= 9; k++) expect_at(k, o_align(8'd0), {nm, "_align"});
        expect_at(10, o_search(8'd0), {nm, "_search"});
    endtask

    task automatic trig_acq(input string nm);
        push_acq(nm);
        step();
        trs_valid_i = 1'b0;
        trs_err_i   = 1'b0;
        steps(9);
    endtask

    // Monitor: every cycle, check all snapshots due now; anything overdue is a miss.
    always @(negedge sys_clk) begin : monitor
        logic [14:0] act;
        act = {state_o, align_o, det_rst_o, locked_o, fail_o, retries_o};
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cyc) begin
                n_tests++;
                if (sb_q[i].cyc < cyc || act !== sb_q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got st=%0d al=%b dr=%b lk=%b fl=%b rt=%0d want st=%0d al=%b dr=%b lk=%b fl=%b rt=%0d",
                             sb_q[i].name, cyc, act[14:12], act[11], act[10], act[9], act[8], act[7:0],
                             sb_q[i].exp[14:12], sb_q[i].exp[11], sb_q[i].exp[10], sb_q[i].exp[9],
                             sb_q[i].exp[8], sb_q[i].exp[7:0]);
                end
                sb_q.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n   = 1'b0;
        enable_i    = 1'b0;
        trs_valid_i = 1'b0;
        trs_err_i   = 1'b0;
        steps(3);
        expect_at(0, o_idle(), "reset");
        sys_rst_n = 1'b1;
        step();
        expect_at(0, o_idle(), "idle_no_en");

        // Basic acquisition and lock with spaced valids.
        enable_i = 1'b1;
        trig_acq("t1");
        pulse(1'b1, 1'b0, 3, o_search(8'd0), "t1_v1");
        pulse(1'b1, 1'b0, 3, o_search(8'd0), "t1_v2");
        pulse(1'b1, 1'b0, 3, o_search(8'd0), "t1_v3");
        pulse(1'b1, 1'b0, 3, o_locked(),     "t1_lock");

        // Errors broken by a valid keep lock; three in a row re-acquire.
        pulse(1'b0, 1'b1, 2, o_locked(), "t4_e1");
        pulse(1'b0, 1'b1, 2, o_locked(), "t4_e2");
        pulse(1'b1, 1'b0, 2, o_locked(), "t4_v");
        pulse(1'b0, 1'b1, 2, o_locked(), "t4_e3");
        pulse(1'b0, 1'b1, 2, o_locked(), "t4_e4");
        trs_err_i = 1'b1;
        trig_acq("t4");

        // Error mid-run restarts the good count.
        pulse(1'b1, 1'b0, 2, o_search(8'd0), "t3_v1");
        pulse(1'b1, 1'b0, 2, o_search(8'd0), "t3_v2");
        pulse(1'b0, 1'b1, 2, o_search(8'd0), "t3_e");
        pulse(1'b1, 1'b0, 2, o_search(8'd0), "t3_v3");
        pulse(1'b1, 1'b0, 2, o_search(8'd0), "t3_v4");
        pulse(1'b1, 1'b0, 2, o_search(8'd0), "t3_v5");
        pulse(1'b1, 1'b0, 2, o_locked(),     "t3_lock");

        // Back-to-back errors, then valid+err together resets the count.
        pulse(1'b0, 1'b1, 1, o_locked(), "t3x_e1");
        pulse(1'b0, 1'b1, 1, o_locked(), "t3x_e2");
        trs_err_i = 1'b1;
        trig_acq("t3x");
        pulse(1'b1, 1'b0, 2, o_search(8'd0), "both_v1");
        pulse(1'b1, 1'b0, 2, o_search(8'd0), "both_v2");
        pulse(1'b1, 1'b0, 2, o_search(8'd0), "both_v3");
        pulse(1'b1, 1'b1, 2, o_search(8'd0), "both_ve");
        pulse(1'b1, 1'b0, 2, o_search(8'd0), "both_v4");
        pulse(1'b1, 1'b0, 2, o_search(8'd0), "both_v5");
        pulse(1'b1, 1'b0, 2, o_search(8'd0), "both_v6");
        pulse(1'b1, 1'b0, 2, o_locked(),     "both_lock");

        // One-cycle enable drop in LOCKED goes to IDLE and restarts.
        enable_i = 1'b0;
        expect_at(1, o_idle(), "t6_idle");
        step();
        enable_i = 1'b1;
        trig_acq("t6");

        // No TRS at all: three windows, retries 1,2,3, then FAIL.
        expect_at(31, o_search(8'd0), "t2_w1_end");
        for (int k = 32; k <= 36; k++) expect_at(k, o_align(8'd1), "t2_align2");
        expect_at(37, o_search(8'd1), "t2_w2_start");
        expect_at(68, o_search(8'd1), "t2_w2_end");
        for (int k = 69; k <= 73; k++) expect_at(k, o_align(8'd2), "t2_align3");
        expect_at(74, o_search(8'd2), "t2_w3_start");
        expect_at(105, o_search(8'd2), "t2_w3_end");
        expect_at(106, o_fail(8'd3), "t2_fail");
        steps(106);
        for (int k = 0; k < 4; k++) pulse(1'b1, 1'b0, 1, o_fail(8'd3), "t2_fail_v");
        pulse(1'b0, 1'b1, 1, o_fail(8'd3), "t2_fail_e");
        steps(5);
        expect_at(0, o_fail(8'd3), "t2_fail_hold");
        enable_i = 1'b0;
        expect_at(1, o_idle(), "t2_idle");
        step();

        // Reset during the third align cycle aborts; restart with enable held.
        enable_i = 1'b1;
        for (int k = 1; k <= 4; k++) expect_at(k, o_drst(), "t5_drst");
        for (int k = 5; k <= 7; k++) expect_at(k, o_align(8'd0), "t5_align");
        steps(7);
        sys_rst_n = 1'b0;
        expect_at(1, o_idle(), "t5_rst");
        step();
        sys_rst_n = 1'b1;
        trig_acq("t5");

        // Fourth valid lands on the window-expiry cycle: lock wins.
        steps(28);
        pulse(1'b1, 1'b0, 1, o_search(8'd0), "edge_v1");
        pulse(1'b1, 1'b0, 1, o_search(8'd0), "edge_v2");
        pulse(1'b1, 1'b0, 1, o_search(8'd0), "edge_v3");
        pulse(1'b1, 1'b0, 1, o_locked(),     "edge_lock");
        expect_at(5, o_locked(), "edge_hold");
        steps(7);

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/align_seq.md
Name: align_seq

Overview:
- Sequencer that drives the SDI word aligner and its TRS detector.
- Sequence: reset detector, issue align pulse, search for consistent TRS, declare lock.
- Retries on timeout up to a limit, then flags failure; while locked, triggers re-acquisition on repeated TRS errors.
- Sits between the SDI deserializer/aligner and the video pipeline's lock/status logic, all in the sys_clk domain.

Parameters:
SETTLE_CYCLES, 64, cycles det_rst_o is held in DRST (≥1)
ALIGN_PULSE, 5, cycles align_o is held high per align attempt (≥1)
CHECK_CYCLES, 1024, search window length in cycles per attempt (≥1)
LOCK_COUNT, 4, consecutive trs_valid_i pulses needed to lock (≥1)
ERR_LIMIT, 3, consecutive trs_err_i pulses in LOCKED that force re-acquisition (≥1)
MAX_RETRIES, 15, failed search windows before FAIL (1..255)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  synchronous active-low reset
enable_i  in  1  level; 1 = run acquisition, 0 = return to IDLE
trs_valid_i  in  1  single-cycle pulse, TRS found at expected position
trs_err_i  in  1  single-cycle pulse, TRS missing or misplaced
align_o  out  1  to aligner n_align_i; high for ALIGN_PULSE cycles per attempt
det_rst_o  out  1  detector reset, high in DRST
locked_o  out  1  high in LOCKED
fail_o  out  1  high in FAIL
retries_o  out  8  failed windows since last IDLE/DRST entry from LOCKED
state_o  out  3  current state encoding, for debug

Behaviour:
- States and encoding: IDLE=0, DRST=1, ALIGN=2, SEARCH=3, LOCKED=4, FAIL=5. All outputs are registered functions of the state register.
- Reset (sys_rst_n=0 at a sys_clk edge):
  - state=IDLE; all counters=0.
  - align_o=0, det_rst_o=0, locked_o=0, fail_o=0, retries_o=0, state_o=0.
  - Reset applied mid-operation aborts immediately, including mid align pulse.
- Priority each cycle: reset > enable_i=0 (any state goes to IDLE next cycle, counters cleared) > state transitions below.
- IDLE: enable_i=1 -> DRST on the next edge; retries=0.
- DRST: det_rst_o=1 for exactly SETTLE_CYCLES cycles, then ALIGN.
- ALIGN:
  - align_o=1 for exactly ALIGN_PULSE cycles, then SEARCH.
  - Window counter and good counter are cleared on entry to SEARCH.
- SEARCH: window counter increments every cycle.
  - trs_err_i=1: good counter=0. Error wins if trs_valid_i is asserted in the same cycle.
  - trs_valid_i=1 alone: good counter+1.
  - Good counter reaching LOCK_COUNT -> LOCKED on the next edge. Lock takes precedence if it coincides with window expiry.
  - Window expiry after CHECK_CYCLES cycles without lock:
    - retries+1 (saturating at 255).
    - If the new value equals MAX_RETRIES -> FAIL, else -> ALIGN.
    - Detector is not reset between retries.
- LOCKED:
  - locked_o=1.
  - trs_err_i increments the error counter; trs_valid_i alone clears it.
  - Error counter reaching ERR_LIMIT -> DRST with retries=0. locked_o drops on the same edge.
- FAIL:
  - fail_o=1, holding until enable_i=0 (-> IDLE). It is never exited spontaneously.
  - trs inputs are ignored.
- trs inputs are ignored in IDLE, DRST and ALIGN.
- Latency: enable_i rising -> det_rst_o high 1 cycle later. Last good trs_valid_i -> locked_o high 1 cycle later.
- Minimum legal window: CHECK_CYCLES=1 means expiry on the first SEARCH cycle.

Test Plan (SETTLE_CYCLES=4, ALIGN_PULSE=5, CHECK_CYCLES=32, LOCK_COUNT=4, ERR_LIMIT=3, MAX_RETRIES=3):
1. Reset, then enable_i=1 -> det_rst_o high 4 cycles, then align_o high 5 cycles, then state_o=3. Then 4 trs_valid_i pulses spaced 3 cycles apart -> locked_o=1 one cycle after the 4th pulse; retries_o=0.
2. Enable with no trs pulses -> align_o pulses 3 times, with 32 SEARCH cycles after each. retries_o steps 1,2,3; fail_o=1 after the 3rd window; align_o stays 0. Then enable_i=0 -> IDLE, fail_o=0, retries_o=0.
3. In SEARCH send valid, valid, err, valid, valid, valid, valid -> locked only after the 7th pulse. A cycle with valid and err together resets the good count.
4. In LOCKED send err, err, valid, err, err -> stays locked. Then a 3rd consecutive err -> locked_o=0, det_rst_o=1 next cycle, retries_o=0.
5. Deassert sys_rst_n during the 3rd align_o cycle -> align_o=0 and state_o=0 at the next edge. With enable_i held 1, the sequence restarts at DRST after reset release.
6. Drop enable_i for 1 cycle in LOCKED -> IDLE, locked_o=0. Re-raising it restarts the full DRST/ALIGN sequence.
